// File: rtl/pc_fetch_ctrl.sv
// PC register and single-outstanding instruction-fetch sequencer feeding decode.
// Optional misaligned-PC trapping is enabled by defining PC_ALIGN_CHECK_EN.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_branch_sel,
    input  logic [31:0] branch_target,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        misalign_fault
);

    typedef enum logic [2:0] {
        S_BOOT  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_OUT   = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t      state_q, state_d, state_n_s;
    logic [31:0] pc_q, pc_d;
    logic        drop_q, drop_d, drop_n_s;
    logic [31:0] instr_q, instr_d, instr_n_s;
    logic [31:0] instr_pc_q, instr_pc_d, instr_pc_n_s;
    logic        req_valid_q, req_valid_d;
    logic        instr_valid_q, instr_valid_d;
    logic        pc_chg_s;
    logic        misalign_s;
    logic        go_fault_s;
    logic [31:0] redir_pc_s;
    logic [31:0] tgt_pc_s;
    logic [31:0] seq_pc_s;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

`ifdef PC_ALIGN_CHECK_EN
    logic fault_q, fault_d;

    assign redir_pc_s     = redirect_pc;
    assign tgt_pc_s       = branch_target;
    assign misalign_s     = (pc_d[1:0] != 2'b00);
    assign fault_d        = (state_d == S_FAULT);
    assign misalign_fault = fault_q;
`else
    // Without the checker, low address bits are simply discarded.
    assign redir_pc_s     = word_align(redirect_pc);
    assign tgt_pc_s       = word_align(branch_target);
    assign misalign_s     = 1'b0;
    assign misalign_fault = 1'b0;
`endif

    assign seq_pc_s       = pc_branch_sel ? tgt_pc_s : (pc_q + 32'd4);
    assign go_fault_s     = pc_chg_s && misalign_s;
    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = pc_q;
    assign instr_valid    = instr_valid_q;
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;

    // Next-state and next-PC selection; redirect outranks every other source.
    always_comb begin
        state_n_s    = state_q;
        pc_d         = pc_q;
        drop_n_s     = drop_q;
        instr_n_s    = instr_q;
        instr_pc_n_s = instr_pc_q;
        pc_chg_s     = 1'b0;
        case (state_q)
            S_BOOT: begin
                state_n_s = S_REQ;
                if (redirect_valid) begin
                    pc_d     = redir_pc_s;
                    pc_chg_s = 1'b1;
                end else begin
                    pc_d = pc_q;
                end
            end
            S_REQ: begin
                if (redirect_valid) begin
                    pc_d     = redir_pc_s;
                    pc_chg_s = 1'b1;
                    // An accepted old-address fetch must have its data thrown away.
                    if (imem_req_ready) begin
                        drop_n_s  = 1'b1;
                        state_n_s = S_WAIT;
                    end else begin
                        state_n_s = S_REQ;
                    end
                end else if (imem_req_ready) begin
                    state_n_s = S_WAIT;
                end else begin
                    state_n_s = S_REQ;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d     = redir_pc_s;
                    pc_chg_s = 1'b1;
                    if (imem_rsp_valid) begin
                        drop_n_s  = 1'b0;
                        state_n_s = S_REQ;
                    end else begin
                        drop_n_s  = 1'b1;
                        state_n_s = S_WAIT;
                    end
                end else if (imem_rsp_valid) begin
                    if (drop_q) begin
                        drop_n_s  = 1'b0;
                        state_n_s = S_REQ;
                    end else begin
                        instr_n_s    = imem_rsp_data;
                        instr_pc_n_s = pc_q;
                        state_n_s    = S_OUT;
                    end
                end else begin
                    state_n_s = S_WAIT;
                end
            end
            S_OUT: begin
                if (redirect_valid) begin
                    pc_d      = redir_pc_s;
                    pc_chg_s  = 1'b1;
                    instr_n_s = NOP_INSTR;
                    state_n_s = S_REQ;
                end else if (instr_ready) begin
                    pc_d      = seq_pc_s;
                    pc_chg_s  = 1'b1;
                    instr_n_s = NOP_INSTR;
                    state_n_s = S_REQ;
                end else begin
                    state_n_s = S_OUT;
                end
            end
            S_FAULT: begin
                if (redirect_valid) begin
                    pc_d      = redir_pc_s;
                    pc_chg_s  = 1'b1;
                    state_n_s = S_REQ;
                end else begin
                    state_n_s = S_FAULT;
                end
            end
            default: begin
                state_n_s = S_BOOT;
            end
        endcase

        // A misaligned new PC parks the sequencer and reports the bad address.
        if (go_fault_s) begin
            state_d    = S_FAULT;
            drop_d     = 1'b0;
            instr_d    = NOP_INSTR;
            instr_pc_d = pc_d;
        end else begin
            state_d    = state_n_s;
            drop_d     = drop_n_s;
            instr_d    = instr_n_s;
            instr_pc_d = instr_pc_n_s;
        end

        req_valid_d   = (state_d == S_REQ);
        instr_valid_d = (state_d == S_OUT);
    end

    // State, PC and registered output flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_BOOT;
            pc_q          <= RESET_VECTOR;
            drop_q        <= 1'b0;
            req_valid_q   <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= NOP_INSTR;
            instr_pc_q    <= RESET_VECTOR;
`ifdef PC_ALIGN_CHECK_EN
            fault_q       <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            drop_q        <= drop_d;
            req_valid_q   <= req_valid_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
`ifdef PC_ALIGN_CHECK_EN
            fault_q       <= fault_d;
`endif
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: transaction-level fetch model plus directed scenarios.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_branch_sel;
    logic [31:0] branch_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        misalign_fault;

    pc_fetch_ctrl dut (
        .clk(clk), .reset(reset),
        .pc_branch_sel(pc_branch_sel), .branch_target(branch_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .misalign_fault(misalign_fault)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Instruction memory: responds lat cycles after acceptance.
    int          lat  = 1;
    bit          bad  = 1'b0;
    bit          spur = 1'b0;
    bit          pend = 1'b0;
    int          cnt  = 0;
    logic [31:0] paddr;
    logic [31:0] log_q[$];

    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            if (reset) begin
                pend = 1'b0;
                cnt  = 0;
            end else begin
                if (spur) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = 32'hBAD0_0000;
                    spur = 1'b0;
                end else if (pend) begin
                    if (cnt <= 1) begin
                        imem_rsp_valid = 1'b1;
                        imem_rsp_data  = bad ? 32'hDEAD_BEEF : mem_word(paddr);
                        bad  = 1'b0;
                        pend = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
                if (imem_req_valid && imem_req_ready) begin
                    pend  = 1'b1;
                    cnt   = lat;
                    paddr = imem_req_addr;
                    log_q.push_back(imem_req_addr);
                end
            end
        end
    end

    // Reference model: expected PC stream, outstanding fetches and the held instruction.
    bit          model_en = 1'b1;
    logic [31:0] exp_pc;
    bit          held_v;
    logic [31:0] held_addr, held_data;
    logic [31:0] qa[$];
    bit          qs[$];

    initial begin
        logic [31:0] a;
        bit          s;
        bit          keep;
        forever begin
            @(negedge clk);
            #3;
            if (reset) begin
                exp_pc = 32'h0;
                held_v = 1'b0;
                qa.delete();
                qs.delete();
            end else if (model_en) begin
                check("m_instr_valid", {31'd0, instr_valid}, {31'd0, held_v});
                if (held_v) begin
                    check("m_instr_pc", instr_pc, held_addr);
                    check("m_instr", instr, held_data);
                end
                if (imem_req_valid) check("m_req_addr", imem_req_addr, exp_pc);
                if (held_v || qa.size() != 0) check("m_req_idle", {31'd0, imem_req_valid}, 32'd0);
`ifndef PC_ALIGN_CHECK_EN
                check("m_no_fault", {31'd0, misalign_fault}, 32'd0);
`endif
                keep = 1'b0;
                if (imem_rsp_valid && qa.size() != 0) begin
                    a    = qa.pop_front();
                    s    = qs.pop_front();
                    keep = !s && !redirect_valid;
                end
                if (redirect_valid) begin
                    foreach (qs[i]) qs[i] = 1'b1;
                    held_v = 1'b0;
                end
                if (imem_req_valid && imem_req_ready) begin
                    qa.push_back(exp_pc);
                    qs.push_back(redirect_valid);
                end
                if (redirect_valid) begin
                    exp_pc = redirect_pc & 32'hFFFF_FFFC;
                end else if (instr_valid && instr_ready) begin
                    exp_pc = pc_branch_sel ? (branch_target & 32'hFFFF_FFFC) : exp_pc + 32'd4;
                    held_v = 1'b0;
                end
                if (keep) begin
                    held_v    = 1'b1;
                    held_addr = a;
                    held_data = imem_rsp_data;
                end
            end
        end
    end

    function automatic logic [31:0] get_log(input int i);
        return (log_q.size() > i) ? log_q[i] : 32'hFFFF_FFFF;
    endfunction

    task automatic wait_valid();
        int n = 0;
        while (!instr_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!instr_valid) check("wait_valid_timeout", {31'd0, instr_valid}, 32'd1);
    endtask

    task automatic wait_req();
        int n = 0;
        while (!imem_req_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!imem_req_valid) check("wait_req_timeout", {31'd0, imem_req_valid}, 32'd1);
    endtask

    task automatic pulse_redirect(input logic [31:0] addr);
        redirect_valid = 1'b1;
        redirect_pc    = addr;
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

`ifdef PC_ALIGN_CHECK_EN
    localparam logic [31:0] R7_ADDR = 32'h0000_0300;
`else
    localparam logic [31:0] R7_ADDR = 32'h0000_0303;
`endif

    initial begin
        int cyc;
        reset          = 1'b1;
        pc_branch_sel  = 1'b0;
        branch_target  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_misalign", {31'd0, misalign_fault}, 32'd0);

        // Boot: sequential fetch stream with an eager decoder.
        reset = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!instr_valid && cyc < 20);
        check("first_valid_latency", cyc, 32'd3);
        repeat (10) @(negedge clk);
        check("boot_addr0", get_log(0), 32'h0);
        check("boot_addr1", get_log(1), 32'h4);
        check("boot_addr2", get_log(2), 32'h8);

        // Taken branch from 0x100 to 0x40.
        instr_ready = 1'b0;
        wait_valid();
        pulse_redirect(32'h0000_0100);
        wait_valid();
        check("br_instr_pc", instr_pc, 32'h0000_0100);
        check("br_instr", instr, 32'h5A5A_0100);
        pc_branch_sel = 1'b1;
        branch_target = 32'h0000_0040;
        instr_ready   = 1'b1;
        @(negedge clk);
        pc_branch_sel = 1'b0;
        branch_target = 32'h0;
        instr_ready   = 1'b0;
        wait_req();
        check("br_req_addr", imem_req_addr, 32'h0000_0040);

        // Redirect while waiting; the late 0xDEADBEEF response must be dropped.
        wait_valid();
        lat = 2;
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        wait_req();
        check("seq_req_addr", imem_req_addr, 32'h0000_0044);
        bad = 1'b1;
        @(negedge clk);
        pulse_redirect(32'h0000_0200);
        lat = 1;
        wait_req();
        check("redir_req_addr", imem_req_addr, 32'h0000_0200);
        wait_valid();
        check("redir_instr_pc", instr_pc, 32'h0000_0200);
        check("redir_instr", instr, 32'h5A5A_0200);

        // Decode stall: held instruction is stable, no fetch, stray response ignored.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 1) spur = 1'b1;
            check("stall_valid", {31'd0, instr_valid}, 32'd1);
            check("stall_pc", instr_pc, 32'h0000_0200);
            check("stall_instr", instr, 32'h5A5A_0200);
            check("stall_no_req", {31'd0, imem_req_valid}, 32'd0);
        end
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;

        // PC wrap from 0xFFFF_FFFC.
        wait_valid();
        check("after_stall_pc", instr_pc, 32'h0000_0204);
        pulse_redirect(32'hFFFF_FFFC);
        wait_valid();
        check("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        wait_req();
        check("wrap_req_addr", imem_req_addr, 32'h0);

        // Redirect in the same cycle the old request is accepted.
        redirect_valid = 1'b1;
        redirect_pc    = R7_ADDR;
        @(negedge clk);
        redirect_valid = 1'b0;
        wait_req();
        check("acc_redir_addr", imem_req_addr, 32'h0000_0300);
        wait_valid();
        check("acc_redir_pc", instr_pc, 32'h0000_0300);
        check("acc_redir_instr", instr, 32'h5A5A_0300);

`ifdef PC_ALIGN_CHECK_EN
        // Misaligned branch parks in the fault state until an aligned redirect.
        model_en      = 1'b0;
        pc_branch_sel = 1'b1;
        branch_target = 32'h0000_0102;
        instr_ready   = 1'b1;
        @(negedge clk);
        pc_branch_sel = 1'b0;
        instr_ready   = 1'b0;
        check("flt_set", {31'd0, misalign_fault}, 32'd1);
        check("flt_instr_pc", instr_pc, 32'h0000_0102);
        check("flt_instr_valid", {31'd0, instr_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("flt_no_req", {31'd0, imem_req_valid}, 32'd0);
            @(negedge clk);
        end
        pulse_redirect(32'h0000_0300);
        check("flt_clear", {31'd0, misalign_fault}, 32'd0);
        check("flt_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("flt_req_addr", imem_req_addr, 32'h0000_0300);
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
